lvds_rx_link_ctrl: RTL and testbench

//  Link controller for the N-lane 8b LVDS receive deserializer bank. Enables lanes via

---
 rtl/lvds_rx_link_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_lvds_rx_link_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lvds_rx_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lvds_rx_link_ctrl
//  Brief    : Link controller for an N-lane 8b LVDS receive deserializer bank.
//             Trains lanes until every masked lane strobes, then deskews the
//             per-lane bytes into one N*8-bit word behind a valid/ready buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module lvds_rx_link_ctrl #(
    parameter int N_LANES   = 5,
    parameter int TRAIN_TO  = 1024,
    parameter int SKEW_MAX  = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [N_LANES-1:0]     lane_mask_i,
    input  logic [N_LANES-1:0]     st_flag_i,
    input  logic [8*N_LANES-1:0]   data_i,
    output logic [N_LANES-1:0]     lvds_control_o,
    output logic [8*N_LANES-1:0]   word_o,
    output logic                   word_valid_o,
    input  logic                   word_ready_i,
    output logic                   link_up_o,
    output logic [1:0]             state_o,
    output logic                   overflow_o,
    output logic [1:0]             retry_o
);

    localparam int TW = $clog2(TRAIN_TO);
    localparam int SW = $clog2(SKEW_MAX + 1);
    localparam int RW = ($clog2(MAX_RETRY + 1) > 2) ? $clog2(MAX_RETRY + 1) : 2;

    localparam logic [TW-1:0] c_TIMER_LAST = TW'(TRAIN_TO - 1);
    localparam logic [SW-1:0] c_SKEW_MAX   = SW'(SKEW_MAX);
    localparam logic [RW-1:0] c_MAX_RETRY  = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    state_t                 r_state,    w_state_nxt;
    logic [N_LANES-1:0]     r_mask,     w_mask_nxt;
    logic [N_LANES-1:0]     r_locked,   w_locked_nxt;
    logic [N_LANES-1:0]     r_got,      w_got_nxt;
    logic [SW-1:0]          r_skew,     w_skew_nxt;
    logic [RW-1:0]          r_retry,    w_retry_nxt;
    logic [TW-1:0]          r_timer,    w_timer_nxt;
    logic                   r_rearm,    w_rearm_nxt;
    logic [8*N_LANES-1:0]   r_asm,      w_asm_nxt;
    logic [8*N_LANES-1:0]   r_word,     w_word_nxt;
    logic                   r_valid,    w_valid_nxt;
    logic                   r_overflow, w_overflow_nxt;

    logic [N_LANES-1:0]     w_stb;
    logic [N_LANES-1:0]     w_got_all;
    logic [N_LANES-1:0]     w_lock_all;
    logic [RW-1:0]          w_retry_inc;
    logic                   w_dup;
    logic                   w_complete;

    // Strobes that count: only lanes in the latched mask participate.
    assign w_stb       = st_flag_i & r_mask;
    assign w_got_all   = r_got | w_stb;
    assign w_lock_all  = r_locked | w_stb;
    assign w_dup       = |(w_stb & r_got);
    assign w_complete  = (w_got_all == r_mask) && !w_dup;
    assign w_retry_inc = r_retry + 1'b1;

    // State register plus all datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_mask     <= '0;
            r_locked   <= '0;
            r_got      <= '0;
            r_skew     <= '0;
            r_retry    <= '0;
            r_timer    <= '0;
            r_rearm    <= 1'b0;
            r_asm      <= '0;
            r_word     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mask     <= w_mask_nxt;
            r_locked   <= w_locked_nxt;
            r_got      <= w_got_nxt;
            r_skew     <= w_skew_nxt;
            r_retry    <= w_retry_nxt;
            r_timer    <= w_timer_nxt;
            r_rearm    <= w_rearm_nxt;
            r_asm      <= w_asm_nxt;
            r_word     <= w_word_nxt;
            r_valid    <= w_valid_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Next-state, training, deskew and output-buffer logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_mask_nxt     = r_mask;
        w_locked_nxt   = r_locked;
        w_got_nxt      = r_got;
        w_skew_nxt     = r_skew;
        w_retry_nxt    = r_retry;
        w_timer_nxt    = r_timer;
        w_rearm_nxt    = 1'b0;
        w_asm_nxt      = r_asm;
        w_word_nxt     = r_word;
        w_valid_nxt    = r_valid;
        w_overflow_nxt = r_overflow;

        // Consumer handshake frees the buffer regardless of state.
        if (r_valid && word_ready_i)
            w_valid_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_valid_nxt    = 1'b0;
                w_word_nxt     = '0;
                w_overflow_nxt = 1'b0;
                w_got_nxt      = '0;
                w_locked_nxt   = '0;
                w_skew_nxt     = '0;
                w_asm_nxt      = '0;
                if (start_i) begin
                    w_mask_nxt  = lane_mask_i;
                    w_timer_nxt = '0;
                    w_retry_nxt = '0;
                    w_state_nxt = (lane_mask_i == '0) ? ST_FAIL : ST_TRAIN;
                end
            end

            ST_TRAIN: begin
                // The re-arm cycle has the deserializers disabled; strobes are
                // meaningless then, so the attempt starts on the next cycle.
                if (!r_rearm) begin
                    w_locked_nxt = w_lock_all;
                    if (w_lock_all == r_mask) begin
                        w_state_nxt = ST_RUN;
                        w_got_nxt   = '0;
                        w_skew_nxt  = '0;
                    end else if (r_timer == c_TIMER_LAST) begin
                        w_retry_nxt  = w_retry_inc;
                        w_timer_nxt  = '0;
                        w_locked_nxt = '0;
                        if (w_retry_inc >= c_MAX_RETRY)
                            w_state_nxt = ST_FAIL;
                        else
                            w_rearm_nxt = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
            end

            ST_RUN: begin
                for (int i = 0; i < N_LANES; i++) begin
                    if (w_stb[i])
                        w_asm_nxt[8*i +: 8] = data_i[8*i +: 8];
                end
                if (w_dup || (!w_complete && (r_skew >= c_SKEW_MAX))) begin
                    // Skew error: throw the partial word away and retrain.
                    w_state_nxt  = ST_TRAIN;
                    w_timer_nxt  = '0;
                    w_locked_nxt = '0;
                    w_got_nxt    = '0;
                    w_skew_nxt   = '0;
                    w_asm_nxt    = '0;
                end else if (w_complete) begin
                    w_got_nxt  = '0;
                    w_skew_nxt = '0;
                    if (!r_valid || word_ready_i) begin
                        w_word_nxt  = w_asm_nxt;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_overflow_nxt = 1'b1;
                    end
                end else begin
                    w_got_nxt = w_got_all;
                    // Skew is zero while no lane has arrived, so this also
                    // starts the count on the first strobe of a word.
                    if (w_got_all != '0)
                        w_skew_nxt = r_skew + 1'b1;
                end
            end

            default: ;  // ST_FAIL waits for start_i to drop
        endcase

        // Dropping start_i aborts from anywhere.
        if (!start_i && (r_state != ST_IDLE)) begin
            w_state_nxt  = ST_IDLE;
            w_valid_nxt  = 1'b0;
            w_word_nxt   = '0;
            w_got_nxt    = '0;
            w_locked_nxt = '0;
            w_skew_nxt   = '0;
            w_rearm_nxt  = 1'b0;
            w_asm_nxt    = '0;
        end
    end

    assign lvds_control_o = (((r_state == ST_TRAIN) && !r_rearm) || (r_state == ST_RUN))
                            ? r_mask : '0;
    assign word_o         = r_word;
    assign word_valid_o   = r_valid;
    assign link_up_o      = (r_state == ST_RUN);
    assign state_o        = r_state;
    assign overflow_o     = r_overflow;
    assign retry_o        = (r_retry > RW'(3)) ? 2'd3 : r_retry[1:0];

endmodule
`default_nettype wire

// File: tb/tb_lvds_rx_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lvds_rx_link_ctrl
//  Brief    : Directed self-checking bench for lvds_rx_link_ctrl
//             (5 lanes, TRAIN_TO=16, SKEW_MAX=4, MAX_RETRY=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lvds_rx_link_ctrl;

    localparam int N = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic           start_i;
    logic [N-1:0]   lane_mask_i;
    logic [N-1:0]   st_flag_i;
    logic [8*N-1:0] data_i;
    logic [N-1:0]   lvds_control_o;
    logic [8*N-1:0] word_o;
    logic           word_valid_o;
    logic           word_ready_i;
    logic           link_up_o;
    logic [1:0]     state_o;
    logic           overflow_o;
    logic [1:0]     retry_o;

    int checks = 0;
    int errors = 0;

    lvds_rx_link_ctrl #(
        .N_LANES  (N),
        .TRAIN_TO (16),
        .SKEW_MAX (4),
        .MAX_RETRY(3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .lane_mask_i   (lane_mask_i),
        .st_flag_i     (st_flag_i),
        .data_i        (data_i),
        .lvds_control_o(lvds_control_o),
        .word_o        (word_o),
        .word_valid_o  (word_valid_o),
        .word_ready_i  (word_ready_i),
        .link_up_o     (link_up_o),
        .state_o       (state_o),
        .overflow_o    (overflow_o),
        .retry_o       (retry_o)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b0;
        start_i      = 1'b0;
        lane_mask_i  = '0;
        st_flag_i    = '0;
        data_i       = '0;
        word_ready_i = 1'b0;
        tick(2);

        // Reset state
        chk("rst_state",    state_o,        2'd0);
        chk("rst_lvds",     lvds_control_o, 5'h00);
        chk("rst_valid",    word_valid_o,   1'b0);
        chk("rst_word",     word_o,         40'h0);
        chk("rst_ovf",      overflow_o,     1'b0);
        chk("rst_retry",    retry_o,        2'd0);
        chk("rst_linkup",   link_up_o,      1'b0);
        reset = 1'b1;
        tick();

        // 1: training with full mask, lock when all lanes strobe together
        lane_mask_i = 5'h1F;
        start_i     = 1'b1;
        tick();
        chk("t1_train",     state_o,        2'd1);
        chk("t1_lvds",      lvds_control_o, 5'h1F);
        tick(3);
        chk("t1_still_trn", state_o,        2'd1);
        st_flag_i = 5'h1F;
        tick();
        st_flag_i = '0;
        chk("t1_run",       state_o,        2'd2);
        chk("t1_linkup",    link_up_o,      1'b1);

        // 2: word spread over four cycles, held until ready
        st_flag_i = 5'h01; data_i = 40'h00_0000_0011; tick();
        st_flag_i = 5'h02; data_i = 40'h00_0000_2200; tick();
        st_flag_i = 5'h04; data_i = 40'h00_0033_0000; tick();
        chk("t2_not_yet",   word_valid_o,   1'b0);
        st_flag_i = 5'h18; data_i = 40'h55_4400_0000; tick();
        st_flag_i = '0;
        chk("t2_valid",     word_valid_o,   1'b1);
        chk("t2_word",      word_o,         40'h5544332211);
        tick();
        chk("t2_held_v",    word_valid_o,   1'b1);
        chk("t2_held_w",    word_o,         40'h5544332211);
        word_ready_i = 1'b1;
        tick();
        word_ready_i = 1'b0;
        chk("t2_taken",     word_valid_o,   1'b0);

        // 3: lane 3 never arrives -> skew error after SKEW_MAX cycles
        st_flag_i = 5'h17; data_i = 40'h77_6666_6666;
        tick();
        st_flag_i = '0;
        tick(3);
        chk("t3_before",    state_o,        2'd2);
        tick();
        chk("t3_train",     state_o,        2'd1);
        chk("t3_novalid",   word_valid_o,   1'b0);
        chk("t3_retry",     retry_o,        2'd0);

        // 4: lane 2 silent -> timeouts, re-arm pulses, then FAIL
        st_flag_i = 5'h1B;
        tick(15);
        chk("t4_pre_to",    retry_o,        2'd0);
        tick();
        chk("t4_rearm1",    lvds_control_o, 5'h00);
        chk("t4_retry1",    retry_o,        2'd1);
        tick();
        chk("t4_rearmed",   lvds_control_o, 5'h1F);
        tick(16);
        chk("t4_rearm2",    lvds_control_o, 5'h00);
        chk("t4_retry2",    retry_o,        2'd2);
        tick(17);
        st_flag_i = '0;
        chk("t4_fail",      state_o,        2'd3);
        chk("t4_retry3",    retry_o,        2'd3);
        chk("t4_lvds_off",  lvds_control_o, 5'h00);
        start_i = 1'b0;
        tick();
        chk("t4_idle",      state_o,        2'd0);

        // 5: buffer full -> second word dropped, overflow sticky
        start_i = 1'b1;
        tick();
        st_flag_i = 5'h1F; tick();
        chk("t5_run",       state_o,        2'd2);
        data_i = 40'hA5A4A3A2A1; tick();
        chk("t5_w1_valid",  word_valid_o,   1'b1);
        chk("t5_no_ovf",    overflow_o,     1'b0);
        data_i = 40'hB5B4B3B2B1; tick();
        st_flag_i = '0;
        chk("t5_w1_held",   word_o,         40'hA5A4A3A2A1);
        chk("t5_ovf",       overflow_o,     1'b1);
        word_ready_i = 1'b1; tick(); word_ready_i = 1'b0;
        chk("t5_drained",   word_valid_o,   1'b0);
        chk("t5_ovf_stky",  overflow_o,     1'b1);

        // Duplicate strobe on one lane before the word completes -> retrain
        st_flag_i = 5'h01; tick();
        tick();
        st_flag_i = '0;
        chk("dup_train",    state_o,        2'd1);

        // Back to IDLE clears overflow
        start_i = 1'b0;
        tick(2);
        chk("idle_ovf_clr", overflow_o,     1'b0);

        // 6: partial mask; unmasked lanes contribute nothing
        lane_mask_i = 5'h05;
        start_i     = 1'b1;
        tick();
        st_flag_i = 5'h05; tick();
        chk("t6_run",       state_o,        2'd2);
        chk("t6_lvds",      lvds_control_o, 5'h05);
        data_i = 40'hFFFFC3FF5A; tick();
        st_flag_i = '0;
        chk("t6_valid",     word_valid_o,   1'b1);
        chk("t6_word",      word_o,         40'h0000C3005A);
        word_ready_i = 1'b1; tick(); word_ready_i = 1'b0;
        st_flag_i = 5'h1A; tick();
        chk("t6_unmasked",  word_valid_o,   1'b0);
        chk("t6_still_run", state_o,        2'd2);
        lane_mask_i = 5'h1F;
        st_flag_i = 5'h05; data_i = 40'h1111_2222_33; tick();
        st_flag_i = '0;
        chk("t6_mask_kept", word_o,         40'h0000220033);

        // Asynchronous reset mid-word clears everything
        st_flag_i = 5'h01; tick();
        st_flag_i = '0;
        #2 reset = 1'b0;
        #1;
        chk("ar_state",     state_o,        2'd0);
        chk("ar_valid",     word_valid_o,   1'b0);
        chk("ar_word",      word_o,         40'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
